ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_keyboard_if.sv | 34 +++
 rtl/ps2_rx.sv | 97 +++++++++
 rtl/ps2_keyboard.sv | 81 ++++++++
 tb/tb_ps2_keyboard.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and decoder state encoding for the PS/2 keyboard receiver.
// No ports; imported by ps2_rx and ps2_keyboard.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] KEY_NONE  = 8'h00;

   typedef enum logic [1:0] {
      StIdle,
      StBreak,
      StExt,
      StExtBreak
   } dec_state_e;

   // Odd parity: data bits plus parity bit must contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: bundles the raw PS/2 lines and the decoded key outputs.
//   ps2_clk, ps2_data : raw PS/2 lines (driven by the keyboard side)
//   keys, key_state   : currently held make code and its held flag
//   code_valid        : one-cycle pulse when keys/key_state are written
//   frame_err         : one-cycle pulse on a discarded frame
// Modports: master = keyboard/host side, slave = decoder.
interface ps2_keyboard_if;

   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keys;
   logic       key_state;
   logic       code_valid;
   logic       frame_err;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  keys,
      input  key_state,
      input  code_valid,
      input  frame_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output keys,
      output key_state,
      output code_valid,
      output frame_err
   );

endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver. Synchronizes and filters the raw lines, shifts in
// 11-bit frames on filtered falling edges, checks start/parity/stop, and abandons
// a partial frame after TIMEOUT_CYC idle cycles.
//   clk, rst      : system clock, async active-low reset
//   ps2_clk/data  : raw asynchronous PS/2 lines
//   data_byte     : received data byte (valid with byte_strobe)
//   byte_strobe   : one-cycle pulse on a good frame
//   frame_err     : one-cycle pulse on a bad frame
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data_byte,
   output logic       byte_strobe,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          filt_level;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] to_cnt;
   logic          filt_done, fall, frame_ok;

   // filt_cnt counts consecutive samples that disagree with the filtered level.
   assign filt_done = (clk_s2 != filt_level) && (filt_cnt == FW'(FILTER_LEN - 1));
   assign fall      = filt_done && filt_level;
   // shreg[0]=start, shreg[8:1]=data, shreg[9]=parity; data_s2 is the stop bit.
   assign frame_ok  = !shreg[0] && data_s2 && odd_parity_ok(shreg[8:1], shreg[9]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1      <= 1'b1;
         clk_s2      <= 1'b1;
         data_s1     <= 1'b1;
         data_s2     <= 1'b1;
         filt_level  <= 1'b1;
         filt_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         to_cnt      <= '0;
         data_byte   <= '0;
         byte_strobe <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         byte_strobe <= 1'b0;
         frame_err   <= 1'b0;
         clk_s1      <= ps2_clk;
         clk_s2      <= clk_s1;
         data_s1     <= ps2_data;
         data_s2     <= data_s1;

         if (clk_s2 == filt_level) begin
            filt_cnt <= '0;
         end else if (filt_done) begin
            filt_level <= clk_s2;
            filt_cnt   <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end

         if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt   <= '0;
               data_byte <= shreg[8:1];
               if (frame_ok) byte_strobe <= 1'b1;
               else          frame_err   <= 1'b1;
            end else begin
               shreg   <= {data_s2, shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // Silent abandon of a stalled partial frame.
            if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
               bit_cnt <= '0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 scan-set-2 keyboard decoder. Tracks the last pressed
// (non-extended) key; extended sequences are consumed without affecting outputs.
//   clk, rst : system clock, async active-low reset
//   bus      : ps2_keyboard_if.slave (raw PS/2 lines in, key state out)
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 25000
) (
   input  logic            clk,
   input  logic            rst,
   ps2_keyboard_if.slave   bus
);

   logic [7:0] rx_byte;
   logic       rx_strobe, rx_err;
   dec_state_e state;
   logic [7:0] key_code;
   logic       held, valid_pulse, err_pulse;

   ps2_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (bus.ps2_clk),
      .ps2_data    (bus.ps2_data),
      .data_byte   (rx_byte),
      .byte_strobe (rx_strobe),
      .frame_err   (rx_err)
   );

   // rx_strobe and rx_err are mutually exclusive, so the registered pulses are too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         key_code    <= KEY_NONE;
         held        <= 1'b0;
         valid_pulse <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         valid_pulse <= 1'b0;
         err_pulse   <= rx_err;
         if (rx_strobe) begin
            case (state)
               StIdle: begin
                  if (rx_byte == PS2_BREAK) begin
                     state <= StBreak;
                  end else if (rx_byte == PS2_EXT) begin
                     state <= StExt;
                  end else begin
                     key_code    <= rx_byte;
                     held        <= 1'b1;
                     valid_pulse <= 1'b1;
                  end
               end
               StBreak: begin
                  // Release of a key other than the held one is ignored.
                  if (rx_byte == key_code) begin
                     key_code    <= KEY_NONE;
                     held        <= 1'b0;
                     valid_pulse <= 1'b1;
                  end
                  state <= StIdle;
               end
               StExt:      state <= (rx_byte == PS2_BREAK) ? StExtBreak : StIdle;
               StExtBreak: state <= StIdle;
               default:    state <= StIdle;
            endcase
         end
      end
   end

   assign bus.keys       = key_code;
   assign bus.key_state  = held;
   assign bus.code_valid = valid_pulse;
   assign bus.frame_err  = err_pulse;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed self-checking bench for ps2_keyboard.
module tb_ps2_keyboard;

   localparam int HALF = 20;  // PS/2 half bit period in system clocks

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #20 clk = ~clk;

   ps2_keyboard_if bus ();

   ps2_keyboard #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (25000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cv_cycles = 0;
   int fe_cycles = 0;
   int overlap = 0;
   int cv0, fe0;

   always @(negedge clk) begin
      if (bus.code_valid === 1'b1) cv_cycles <= cv_cycles + 1;
      if (bus.frame_err === 1'b1) fe_cycles <= fe_cycles + 1;
      if (bus.code_valid === 1'b1 && bus.frame_err === 1'b1) overlap <= overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.ps2_data = bits[i];
         wait_cyc(HALF);
         bus.ps2_clk = 1'b0;
         wait_cyc(HALF);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      logic p;
      p = ~(^b) ^ bad;
      send_bits({1'b1, p, b, 1'b0}, 11);
      wait_cyc(2 * HALF);
   endtask

   task automatic mark();
      cv0 = cv_cycles;
      fe0 = fe_cycles;
   endtask

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;

      // Reset held with random line activity.
      repeat (300) begin
         @(negedge clk);
         bus.ps2_clk  = 1'($urandom_range(0, 1));
         bus.ps2_data = 1'($urandom_range(0, 1));
      end
      check("rst_keys", 32'(bus.keys), 32'h00);
      check("rst_key_state", 32'(bus.key_state), 32'h0);
      check("rst_code_valid_cnt", cv_cycles, 0);
      check("rst_frame_err_cnt", fe_cycles, 0);
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cyc(10);
      rst = 1'b1;
      wait_cyc(20);

      // Partial frame interrupted by reset must be discarded.
      mark();
      send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 4);
      rst = 1'b0;
      wait_cyc(5);
      rst = 1'b1;
      wait_cyc(20);

      // Make 5A.
      send_frame(8'h5A, 1'b0);
      check("make5a_keys", 32'(bus.keys), 32'h5A);
      check("make5a_state", 32'(bus.key_state), 32'h1);
      check("make5a_cv_cycles", cv_cycles - cv0, 1);
      check("make5a_no_err", fe_cycles - fe0, 0);

      // Break 5A.
      mark();
      send_frame(8'hF0, 1'b0);
      check("f0_no_cv", cv_cycles - cv0, 0);
      check("f0_keys_kept", 32'(bus.keys), 32'h5A);
      send_frame(8'h5A, 1'b0);
      check("brk5a_keys", 32'(bus.keys), 32'h00);
      check("brk5a_state", 32'(bus.key_state), 32'h0);
      check("brk5a_cv_cycles", cv_cycles - cv0, 1);

      // 0x58 with wrong parity.
      mark();
      send_frame(8'h58, 1'b1);
      check("par_err_cycles", fe_cycles - fe0, 1);
      check("par_no_cv", cv_cycles - cv0, 0);
      check("par_keys", 32'(bus.keys), 32'h00);
      check("par_state", 32'(bus.key_state), 32'h0);

      // Five bits, timeout, then a full 0x43 frame.
      mark();
      send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 5);
      wait_cyc(25050);
      check("to_no_err", fe_cycles - fe0, 0);
      check("to_no_cv", cv_cycles - cv0, 0);
      send_frame(8'h43, 1'b0);
      check("to43_keys", 32'(bus.keys), 32'h43);
      check("to43_state", 32'(bus.key_state), 32'h1);
      check("to43_cv", cv_cycles - cv0, 1);
      check("to43_no_err", fe_cycles - fe0, 0);

      // Last pressed wins; release of a non-held key is ignored.
      mark();
      send_frame(8'h5A, 1'b0);
      send_frame(8'h58, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h5A, 1'b0);
      check("lpw_keys", 32'(bus.keys), 32'h58);
      check("lpw_state", 32'(bus.key_state), 32'h1);
      check("lpw_cv", cv_cycles - cv0, 2);

      // Typematic repeat.
      mark();
      send_frame(8'h58, 1'b0);
      check("rep_cv", cv_cycles - cv0, 1);
      check("rep_keys", 32'(bus.keys), 32'h58);

      // Extended make and break leave outputs alone.
      mark();
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("ext_keys", 32'(bus.keys), 32'h58);
      check("ext_state", 32'(bus.key_state), 32'h1);
      check("ext_no_cv", cv_cycles - cv0, 0);

      // Bad frame while a key is held.
      mark();
      send_frame(8'hF0, 1'b1);
      check("bad_held_err", fe_cycles - fe0, 1);
      check("bad_held_keys", 32'(bus.keys), 32'h58);
      check("bad_held_state", 32'(bus.key_state), 32'h1);

      // Decoder back in idle: release 58.
      mark();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h58, 1'b0);
      check("rel58_keys", 32'(bus.keys), 32'h00);
      check("rel58_state", 32'(bus.key_state), 32'h0);
      check("rel58_cv", cv_cycles - cv0, 1);

      check("no_overlap", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
